cpu_run_ctrl: RTL and testbench

//  Run-control unit between the board/bench clock and the single-cycle CPU top.

---
 rtl/cpu_run_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run-control unit sitting between the bench/board clock and a single-cycle
//   CPU. It sequences the core reset and gates CPU progress with a clock
//   enable. Supported modes are free run, single step, host halt, NUM_BP PC
//   breakpoints and a cycle limit. It also counts executed cycles.
//
// Ports
//   clk, rst_n   system clock (rising edge), async active-low reset
//   pc           CPU pc of the instruction executing this cycle
//   run, step    HALT -> RUN pulse / execute exactly one instruction from HALT
//   halt_req     stop before the current instruction
//   bp_en        per-breakpoint enable
//   bp_addr      breakpoint i at bits [i*PC_W +: PC_W]
//   max_cycles   halt when cycle_cnt reaches this value, 0 = no limit
//   core_rst_n   registered active-low reset to the CPU
//   core_ce      CPU clock enable (combinational)
//   halted       registered, high while the FSM sits in HALT
//   halt_cause   0 none, 1 request, 2 breakpoint, 3 limit, 4 step
//   bp_idx       breakpoint responsible for the last breakpoint halt
//   cycle_cnt    saturating count of cycles with core_ce=1
//
// state | meaning
// ------+------------------------------------------------------------
// HOLD  | core held in reset for RST_CYCLES clocks after rst_n release
// RUN   | free run, core_ce=1 until a stop condition is seen
// HALT  | core frozen, waiting for step/run
// STEP  | one enabled cycle, then back to HALT
module cpu_run_ctrl #(
  parameter int PC_W         = 8,
  parameter int NUM_BP       = 2,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 4,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_W-1:0]        pc,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [CNT_W-1:0]       max_cycles,
  output logic                   core_rst_n,
  output logic                   core_ce,
  output logic                   halted,
  output logic [2:0]             halt_cause,
  output logic [2:0]             bp_idx,
  output logic [CNT_W-1:0]       cycle_cnt
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              bp_skip;
  logic              bp_hit;
  logic [2:0]        bp_hit_idx;
  logic              limit_hit;
  logic              stop_run;

  // Scan upwards and keep the first match so the lowest index wins.
  always_comb begin
    bp_hit     = 1'b0;
    bp_hit_idx = 3'd0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (!bp_hit && bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
        bp_hit     = 1'b1;
        bp_hit_idx = 3'(i);
      end
    end
  end

  assign limit_hit = (max_cycles != '0) && (cycle_cnt >= max_cycles);
  // bp_skip lets a resume from a breakpoint execute the instruction it stopped on.
  assign stop_run  = halt_req || limit_hit || (bp_hit && !bp_skip);

  always_comb begin
    core_ce = 1'b0;
    case (state)
      S_RUN:   core_ce = !stop_run;
      S_STEP:  core_ce = !(halt_req || limit_hit);
      default: core_ce = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HOLD;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= 3'd0;
      bp_idx     <= 3'd0;
      cycle_cnt  <= '0;
      bp_skip    <= 1'b0;
    end else begin
      if (core_ce) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
        bp_skip <= 1'b0;
      end

      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            core_rst_n <= 1'b1;
            state      <= START_HALTED ? S_HALT : S_RUN;
            halted     <= START_HALTED;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_RUN: begin
          if (halt_req) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= 3'd1;
          end else if (limit_hit) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= 3'd3;
          end else if (bp_hit && !bp_skip) begin
            state      <= S_HALT;
            halted     <= 1'b1;
            halt_cause <= 3'd2;
            bp_idx     <= bp_hit_idx;
          end
        end

        S_HALT: begin
          if (halt_req) begin
            halted <= 1'b1;
          end else if (step) begin
            state      <= S_STEP;
            halted     <= 1'b0;
            halt_cause <= 3'd0;
            bp_skip    <= 1'b1;
          end else if (run) begin
            state      <= S_RUN;
            halted     <= 1'b0;
            halt_cause <= 3'd0;
            bp_skip    <= 1'b1;
          end
        end

        S_STEP: begin
          state  <= S_HALT;
          halted <= 1'b1;
          if (halt_req)       halt_cause <= 3'd1;
          else if (limit_hit) halt_cause <= 3'd3;
          else                halt_cause <= 3'd4;
        end

        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance: default parameters (RST_CYCLES=4, START_HALTED=0)
  logic        rst_n = 1'b0;
  logic [7:0]  pc;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [1:0]  bp_en = 2'b00;
  logic [15:0] bp_addr = 16'h0;
  logic [31:0] max_cycles = 32'd0;
  logic        core_rst_n, core_ce, halted;
  logic [2:0]  halt_cause, bp_idx;
  logic [31:0] cycle_cnt;

  cpu_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .run(run), .step(step),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .max_cycles(max_cycles), .core_rst_n(core_rst_n), .core_ce(core_ce),
    .halted(halted), .halt_cause(halt_cause), .bp_idx(bp_idx),
    .cycle_cnt(cycle_cnt)
  );

  // Second instance: starts halted, short reset, 4-bit counter for saturation
  logic        h_rst_n = 1'b0;
  logic [7:0]  h_pc;
  logic        h_run = 1'b0, h_step = 1'b0, h_halt_req = 1'b0;
  logic [1:0]  h_bp_en = 2'b00;
  logic [15:0] h_bp_addr = 16'h0;
  logic [3:0]  h_max = 4'd0;
  logic        h_core_rst_n, h_core_ce, h_halted;
  logic [2:0]  h_cause, h_bp_idx;
  logic [3:0]  h_cnt;

  cpu_run_ctrl #(.CNT_W(4), .RST_CYCLES(2), .START_HALTED(1'b1)) dut_h (
    .clk(clk), .rst_n(h_rst_n), .pc(h_pc), .run(h_run), .step(h_step),
    .halt_req(h_halt_req), .bp_en(h_bp_en), .bp_addr(h_bp_addr),
    .max_cycles(h_max), .core_rst_n(h_core_rst_n), .core_ce(h_core_ce),
    .halted(h_halted), .halt_cause(h_cause), .bp_idx(h_bp_idx),
    .cycle_cnt(h_cnt)
  );

  // Minimal CPU models: pc advances by 4 on every enabled clock
  always_ff @(posedge clk or negedge core_rst_n)
    if (!core_rst_n) pc <= 8'h00;
    else if (core_ce) pc <= pc + 8'd4;

  always_ff @(posedge clk or negedge h_core_rst_n)
    if (!h_core_rst_n) h_pc <= 8'h00;
    else if (h_core_ce) h_pc <= h_pc + 8'd4;

  typedef struct {
    logic [1:0]  en;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [31:0] mx;
    logic [7:0]  epc;
    logic [2:0]  ecause;
    logic [2:0]  eidx;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_main();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_halted(input string name);
    int k;
    for (k = 0; k < 200 && !halted; k++) tick();
    if (!halted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for halted got 0 expected 1", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    //               en     a0     a1     max    pc     cause idx  cnt
    vecs[0] = '{2'b01, 8'h0C, 8'h00, 32'd0, 8'h0C, 3'd2, 3'd0, 32'd3};
    vecs[1] = '{2'b10, 8'h08, 8'h18, 32'd0, 8'h18, 3'd2, 3'd1, 32'd6};
    vecs[2] = '{2'b11, 8'h14, 8'h08, 32'd0, 8'h08, 3'd2, 3'd1, 32'd2};
    vecs[3] = '{2'b11, 8'h10, 8'h10, 32'd0, 8'h10, 3'd2, 3'd0, 32'd4};
    vecs[4] = '{2'b00, 8'h00, 8'h00, 32'd5, 8'h14, 3'd3, 3'd0, 32'd5};
    vecs[5] = '{2'b01, 8'h20, 8'h00, 32'd3, 8'h0C, 3'd3, 3'd0, 32'd3};
    vecs[6] = '{2'b01, 8'h08, 8'h00, 32'd2, 8'h08, 3'd3, 3'd0, 32'd2};
    vecs[7] = '{2'b01, 8'h00, 8'h00, 32'd0, 8'h00, 3'd2, 3'd0, 32'd0};

    // Reset values
    tick();
    chk("rst core_rst_n", 32'(core_rst_n), 0);
    chk("rst core_ce", 32'(core_ce), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst cause", 32'(halt_cause), 0);
    chk("rst bp_idx", 32'(bp_idx), 0);
    chk("rst cycle_cnt", cycle_cnt, 0);

    // Reset release timing and free run
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("hold after 3 edges", 32'(core_rst_n), 0);
    chk("hold ce", 32'(core_ce), 0);
    tick();
    chk("core_rst_n after 4th edge", 32'(core_rst_n), 1);
    chk("ce first run cycle", 32'(core_ce), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("free run cycle_cnt", cycle_cnt, 10);
    chk("free run pc", 32'(pc), 32'h28);
    chk("free run halted", 32'(halted), 0);

    // Table of breakpoint / limit configurations, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      bp_en      = vecs[v].en;
      bp_addr    = {vecs[v].a1, vecs[v].a0};
      max_cycles = vecs[v].mx;
      exp_q.push_back(vecs[v]);
      reset_main();
      wait_halted($sformatf("vec%0d", v));
      e = exp_q.pop_front();
      chk($sformatf("vec%0d pc", v), 32'(pc), 32'(e.epc));
      chk($sformatf("vec%0d cause", v), 32'(halt_cause), 32'(e.ecause));
      chk($sformatf("vec%0d bp_idx", v), 32'(bp_idx), 32'(e.eidx));
      chk($sformatf("vec%0d cycle_cnt", v), cycle_cnt, e.ecnt);
      chk($sformatf("vec%0d ce in halt", v), 32'(core_ce), 0);
    end
    max_cycles = 32'd0;

    // Breakpoint halt, single step, then run without re-halting
    bp_en = 2'b01; bp_addr = {8'h00, 8'h0C};
    reset_main();
    wait_halted("step setup");
    chk("bp halt cnt", cycle_cnt, 3);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step ce", 32'(core_ce), 1);
    chk("step halted low", 32'(halted), 0);
    tick();
    chk("after step ce", 32'(core_ce), 0);
    chk("after step pc", 32'(pc), 32'h10);
    chk("after step cause", 32'(halt_cause), 4);
    chk("after step cnt", cycle_cnt, 4);
    chk("after step halted", 32'(halted), 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("resume pc", 32'(pc), 32'h60);
    chk("resume halted", 32'(halted), 0);

    // Resume directly from a breakpoint executes that instruction once
    reset_main();
    wait_halted("skip setup");
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("bp_skip ce at bp pc", 32'(core_ce), 1);
    chk("bp_skip pc", 32'(pc), 32'h0C);
    tick();
    chk("bp_skip next pc", 32'(pc), 32'h10);

    // halt_req and breakpoint in the same cycle; request wins
    reset_main();
    bp_en = 2'b01; bp_addr = {8'h00, 8'h0C};
    for (int k = 0; k < 50 && pc != 8'h08; k++) tick();
    tick();
    chk("hreq pc at stop", 32'(pc), 32'h0C);
    halt_req = 1'b1;
    chk("hreq ce", 32'(core_ce), 0);
    chk("hreq halted not yet", 32'(halted), 0);
    tick();
    halt_req = 1'b0;
    chk("hreq halted", 32'(halted), 1);
    chk("hreq cause", 32'(halt_cause), 1);

    // halt_req in HALT outranks step
    halt_req = 1'b1; step = 1'b1;
    tick();
    halt_req = 1'b0; step = 1'b0;
    chk("hreq over step halted", 32'(halted), 1);
    chk("hreq over step ce", 32'(core_ce), 0);
    chk("hreq over step pc", 32'(pc), 32'h0C);

    // Asynchronous reset in the middle of a run
    bp_en = 2'b00;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async core_rst_n", 32'(core_rst_n), 0);
    chk("async core_ce", 32'(core_ce), 0);
    chk("async cycle_cnt", cycle_cnt, 0);
    chk("async halted", 32'(halted), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rehold after 3", 32'(core_rst_n), 0);
    tick();
    chk("rehold after 4", 32'(core_rst_n), 1);
    chk("rehold ce", 32'(core_ce), 1);

    // START_HALTED instance
    tick();
    h_rst_n = 1'b1;
    tick();
    chk("h hold after 1", 32'(h_core_rst_n), 0);
    tick();
    chk("h core_rst_n", 32'(h_core_rst_n), 1);
    chk("h halted at start", 32'(h_halted), 1);
    chk("h cause at start", 32'(h_cause), 0);
    chk("h ce at start", 32'(h_core_ce), 0);
    h_step = 1'b1; h_run = 1'b1;
    tick();
    h_step = 1'b0; h_run = 1'b0;
    chk("h step ce", 32'(h_core_ce), 1);
    tick();
    chk("h step halted", 32'(h_halted), 1);
    chk("h step cause", 32'(h_cause), 4);
    chk("h step pc", 32'(h_pc), 4);
    chk("h step cnt", 32'(h_cnt), 1);
    chk("h step ce off", 32'(h_core_ce), 0);
    h_run = 1'b1;
    tick();
    h_run = 1'b0;
    chk("h run ce", 32'(h_core_ce), 1);
    h_run = 1'b1;
    tick();
    h_run = 1'b0;
    chk("h run in run halted", 32'(h_halted), 0);
    chk("h run in run ce", 32'(h_core_ce), 1);
    for (int i = 0; i < 20; i++) tick();
    chk("h cnt saturates", 32'(h_cnt), 15);
    chk("h ce after saturation", 32'(h_core_ce), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
